// File: rtl/cp_operand_bypass.sv
// rtl/cp_operand_bypass.sv - CP ID-stage operand latch, RAW forwarding and load-use stall
//
// Purpose:
//   Latches the register-file read data for the instruction moving from IF
//   to ID. Resolves read-after-write hazards against the EX and WB results
//   and raises a stall for the pipeline controller when a load result is
//   not yet available. Delivers the final operands A/B to the CP execute stage.
//
// Configuration macro:
//   CP_BP_EX_FORWARD_EN - when defined, EX ALU results are forwarded into ID.
//                         When undefined there is no EX path: any EX match
//                         stalls (1 cycle for ALU, LOAD_USE_STALL for loads).
//
// Ports:
//   iClk                     clock, rising edge
//   iRst                     synchronous reset, active-high
//   iIF_Valid                valid instruction in IF
//   iIF_RF_Read_Addr_A/B     IF source register indices
//   iRF_BP_Read_Data_A/B     register-file combinational read data
//   iEX_Write_Addr/Data      EX destination index / ALU result
//   iEX_Write_Enable         EX writes the register file
//   iEX_Is_Load              EX instruction is a load (data not yet valid)
//   iWB_RF_Write_Addr/Data   WB destination index / data
//   iWB_RF_Write_Enable      WB write enable
//   iFlush                   branch flush, kills the ID instruction
//   oBP_ID_Valid             ID holds a valid instruction
//   oBP_ID_Operand_A/B       forwarded operands to EX
//   oBP_Stall                hold IF/ID and inject an EX bubble

module cp_operand_bypass #(
    parameter int DATA_W         = 32,
    parameter int IDX_W          = 5,
    parameter int NUM_REGS       = 28,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iIF_Valid,
    input  logic [IDX_W-1:0]  iIF_RF_Read_Addr_A,
    input  logic [IDX_W-1:0]  iIF_RF_Read_Addr_B,
    input  logic [DATA_W-1:0] iRF_BP_Read_Data_A,
    input  logic [DATA_W-1:0] iRF_BP_Read_Data_B,
    input  logic [IDX_W-1:0]  iEX_Write_Addr,
    input  logic [DATA_W-1:0] iEX_Write_Data,
    input  logic              iEX_Write_Enable,
    input  logic              iEX_Is_Load,
    input  logic [IDX_W-1:0]  iWB_RF_Write_Addr,
    input  logic [DATA_W-1:0] iWB_RF_Write_Data,
    input  logic              iWB_RF_Write_Enable,
    input  logic              iFlush,
    output logic              oBP_ID_Valid,
    output logic [DATA_W-1:0] oBP_ID_Operand_A,
    output logic [DATA_W-1:0] oBP_ID_Operand_B,
    output logic              oBP_Stall
);

    localparam logic       ST_RUN  = 1'b0;
    localparam logic       ST_WAIT = 1'b1;
    localparam logic [1:0] STALL_INIT  = 2'(LOAD_USE_STALL - 1);
    localparam logic [IDX_W:0] NUM_REGS_W = (IDX_W + 1)'(NUM_REGS);

    logic              idValid;
    logic [IDX_W-1:0]  idAddrA, idAddrB;
    logic [DATA_W-1:0] idDataA, idDataB;
    logic              state;
    logic [1:0]        cnt;

    // r0 and indices beyond the architected file are hardwired zero and
    // never take part in forwarding or hazard detection.
    function automatic logic addrOk(input logic [IDX_W-1:0] a);
        return (a != '0) && ({1'b0, a} < NUM_REGS_W);
    endfunction

    logic exHitA, exHitB, wbHitA, wbHitB;
    logic exFwdA, exFwdB, hazard;
    logic wbThroughA, wbThroughB;

    always_comb begin
        exHitA = iEX_Write_Enable && addrOk(iEX_Write_Addr) && (iEX_Write_Addr == idAddrA);
        exHitB = iEX_Write_Enable && addrOk(iEX_Write_Addr) && (iEX_Write_Addr == idAddrB);
        wbHitA = iWB_RF_Write_Enable && addrOk(iWB_RF_Write_Addr) && (iWB_RF_Write_Addr == idAddrA);
        wbHitB = iWB_RF_Write_Enable && addrOk(iWB_RF_Write_Addr) && (iWB_RF_Write_Addr == idAddrB);
        // The RF returns the old value when it is written in the same cycle,
        // so a matching WB write replaces the captured read data.
        wbThroughA = iWB_RF_Write_Enable && addrOk(iWB_RF_Write_Addr) &&
                     (iWB_RF_Write_Addr == iIF_RF_Read_Addr_A);
        wbThroughB = iWB_RF_Write_Enable && addrOk(iWB_RF_Write_Addr) &&
                     (iWB_RF_Write_Addr == iIF_RF_Read_Addr_B);
`ifdef CP_BP_EX_FORWARD_EN
        exFwdA = exHitA && !iEX_Is_Load;
        exFwdB = exHitB && !iEX_Is_Load;
        hazard = idValid && iEX_Is_Load && (exHitA || exHitB);
`else
        exFwdA = 1'b0;
        exFwdB = 1'b0;
        hazard = idValid && (exHitA || exHitB);
`endif
    end

    // EX has priority over WB: it is the younger write to the same register.
    always_comb begin
        oBP_ID_Operand_A = '0;
        oBP_ID_Operand_B = '0;
        if (addrOk(idAddrA))
            oBP_ID_Operand_A = exFwdA ? iEX_Write_Data :
                               wbHitA ? iWB_RF_Write_Data : idDataA;
        if (addrOk(idAddrB))
            oBP_ID_Operand_B = exFwdB ? iEX_Write_Data :
                               wbHitB ? iWB_RF_Write_Data : idDataB;
    end

    always_comb begin
        oBP_Stall = 1'b0;
        if (!iFlush)
            oBP_Stall = (state == ST_WAIT) ? 1'b1 : hazard;
    end

    assign oBP_ID_Valid = idValid;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            idValid <= 1'b0;
            idAddrA <= '0;
            idAddrB <= '0;
            idDataA <= '0;
            idDataB <= '0;
            state   <= ST_RUN;
            cnt     <= '0;
        end else begin
            if (!oBP_Stall) begin
                idValid <= iIF_Valid && !iFlush;
                idAddrA <= iIF_RF_Read_Addr_A;
                idAddrB <= iIF_RF_Read_Addr_B;
                idDataA <= wbThroughA ? iWB_RF_Write_Data : iRF_BP_Read_Data_A;
                idDataB <= wbThroughB ? iWB_RF_Write_Data : iRF_BP_Read_Data_B;
            end else begin
                // Held instruction keeps picking up WB writes so the load
                // result is in the latch once the stall releases.
                if (wbHitA) idDataA <= iWB_RF_Write_Data;
                if (wbHitB) idDataB <= iWB_RF_Write_Data;
            end

            if (iFlush) begin
                state <= ST_RUN;
                cnt   <= '0;
            end else if (state == ST_RUN) begin
                // The first stall cycle is spent in RUN; WAIT covers the rest.
                if (hazard && iEX_Is_Load && (LOAD_USE_STALL > 1)) begin
                    state <= ST_WAIT;
                    cnt   <= STALL_INIT;
                end
            end else begin
                cnt <= cnt - 2'd1;
                if (cnt == 2'd1)
                    state <= ST_RUN;
            end
        end
    end

endmodule

// File: tb/tb_cp_operand_bypass.sv
// tb/tb_cp_operand_bypass.sv - directed self-checking bench for cp_operand_bypass

module tb_cp_operand_bypass;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iIF_Valid;
    logic [4:0]  iIF_RF_Read_Addr_A, iIF_RF_Read_Addr_B;
    logic [31:0] iRF_BP_Read_Data_A, iRF_BP_Read_Data_B;
    logic [4:0]  iEX_Write_Addr;
    logic [31:0] iEX_Write_Data;
    logic        iEX_Write_Enable, iEX_Is_Load;
    logic [4:0]  iWB_RF_Write_Addr;
    logic [31:0] iWB_RF_Write_Data;
    logic        iWB_RF_Write_Enable;
    logic        iFlush;
    logic        oBP_ID_Valid;
    logic [31:0] oBP_ID_Operand_A, oBP_ID_Operand_B;
    logic        oBP_Stall;

    int total = 0;
    int bad   = 0;

    cp_operand_bypass #(
        .DATA_W(32), .IDX_W(5), .NUM_REGS(28), .LOAD_USE_STALL(2)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iIF_Valid(iIF_Valid),
        .iIF_RF_Read_Addr_A(iIF_RF_Read_Addr_A), .iIF_RF_Read_Addr_B(iIF_RF_Read_Addr_B),
        .iRF_BP_Read_Data_A(iRF_BP_Read_Data_A), .iRF_BP_Read_Data_B(iRF_BP_Read_Data_B),
        .iEX_Write_Addr(iEX_Write_Addr), .iEX_Write_Data(iEX_Write_Data),
        .iEX_Write_Enable(iEX_Write_Enable), .iEX_Is_Load(iEX_Is_Load),
        .iWB_RF_Write_Addr(iWB_RF_Write_Addr), .iWB_RF_Write_Data(iWB_RF_Write_Data),
        .iWB_RF_Write_Enable(iWB_RF_Write_Enable), .iFlush(iFlush),
        .oBP_ID_Valid(oBP_ID_Valid), .oBP_ID_Operand_A(oBP_ID_Operand_A),
        .oBP_ID_Operand_B(oBP_ID_Operand_B), .oBP_Stall(oBP_Stall)
    );

    always #5 iClk = ~iClk;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic settle();
        @(negedge iClk);
    endtask

    task automatic idle();
        iIF_Valid = 0; iIF_RF_Read_Addr_A = 0; iIF_RF_Read_Addr_B = 0;
        iRF_BP_Read_Data_A = 0; iRF_BP_Read_Data_B = 0;
        iEX_Write_Addr = 0; iEX_Write_Data = 0; iEX_Write_Enable = 0; iEX_Is_Load = 0;
        iWB_RF_Write_Addr = 0; iWB_RF_Write_Data = 0; iWB_RF_Write_Enable = 0;
        iFlush = 0;
    endtask

    task automatic exWrite(input logic [4:0] a, input logic [31:0] d, input logic ld);
        iEX_Write_Enable = 1; iEX_Write_Addr = a; iEX_Write_Data = d; iEX_Is_Load = ld;
    endtask

    task automatic wbWrite(input logic [4:0] a, input logic [31:0] d);
        iWB_RF_Write_Enable = 1; iWB_RF_Write_Addr = a; iWB_RF_Write_Data = d;
    endtask

    // Move one instruction into ID with no hazards pending, then go idle.
    task automatic loadId(input logic [4:0] a, input logic [4:0] b,
                          input logic [31:0] da, input logic [31:0] db);
        idle();
        iIF_Valid = 1; iIF_RF_Read_Addr_A = a; iIF_RF_Read_Addr_B = b;
        iRF_BP_Read_Data_A = da; iRF_BP_Read_Data_B = db;
        step();
        idle();
    endtask

    initial begin
        idle();
        iRst = 1;
        step();
        step();
        iRst = 0;
        settle();
        checkEq("rst_valid", 32'(oBP_ID_Valid), 0);
        checkEq("rst_stall", 32'(oBP_Stall), 0);
        checkEq("rst_opa", oBP_ID_Operand_A, 0);
        checkEq("rst_opb", oBP_ID_Operand_B, 0);

        // EX ALU result r3 = 0x11 while ID reads r3
        loadId(3, 2, 32'h100, 32'h22);
        exWrite(3, 32'h11, 0);
        settle();
        checkEq("alu_valid", 32'(oBP_ID_Valid), 1);
        checkEq("alu_opb", oBP_ID_Operand_B, 32'h22);
`ifdef CP_BP_EX_FORWARD_EN
        checkEq("alu_fwd_opa", oBP_ID_Operand_A, 32'h11);
        checkEq("alu_fwd_stall", 32'(oBP_Stall), 0);
`else
        checkEq("alu_nofwd_stall", 32'(oBP_Stall), 1);
        step();
        idle();
        wbWrite(3, 32'h11);
        settle();
        checkEq("alu_nofwd_stall2", 32'(oBP_Stall), 0);
        checkEq("alu_nofwd_opa", oBP_ID_Operand_A, 32'h11);
`endif
        step();
        idle();

        // Load to r5, ID reads B=r5: two stall cycles then load data
        loadId(1, 5, 32'hA, 32'h55);
        exWrite(5, 32'hBAD, 1);
        settle();
        checkEq("lu_stall0", 32'(oBP_Stall), 1);
        step();
        idle();
        wbWrite(5, 32'h5A5A);
        settle();
        checkEq("lu_stall1", 32'(oBP_Stall), 1);
        checkEq("lu_opb_wb", oBP_ID_Operand_B, 32'h5A5A);
        step();
        idle();
        settle();
        checkEq("lu_release", 32'(oBP_Stall), 0);
        checkEq("lu_opb_snoop", oBP_ID_Operand_B, 32'h5A5A);
        checkEq("lu_opa", oBP_ID_Operand_A, 32'hA);

        // Both operands depend on the same load: one stall window
        loadId(8, 8, 32'h1, 32'h1);
        exWrite(8, 32'h0, 1);
        settle();
        checkEq("same_stall0", 32'(oBP_Stall), 1);
        step();
        idle();
        wbWrite(8, 32'h77);
        settle();
        checkEq("same_opa", oBP_ID_Operand_A, 32'h77);
        checkEq("same_opb", oBP_ID_Operand_B, 32'h77);
        step();
        idle();
        settle();
        checkEq("same_release", 32'(oBP_Stall), 0);

        // WB write-through: RF returns stale r7 while WB writes it
        step();
        idle();
        iIF_Valid = 1; iIF_RF_Read_Addr_A = 7; iRF_BP_Read_Data_A = 32'h1111;
        wbWrite(7, 32'hDEAD);
        step();
        idle();
        settle();
        checkEq("wt_opa", oBP_ID_Operand_A, 32'hDEAD);
        checkEq("wt_opb_r0", oBP_ID_Operand_B, 0);

        // EX and WB both write r4; r0 never forwarded
        loadId(4, 0, 32'h44, 32'h0);
        exWrite(4, 32'h1, 0);
        wbWrite(4, 32'h2);
        settle();
`ifdef CP_BP_EX_FORWARD_EN
        checkEq("prio_opa", oBP_ID_Operand_A, 32'h1);
        checkEq("prio_stall", 32'(oBP_Stall), 0);
`else
        checkEq("prio_nofwd_opa", oBP_ID_Operand_A, 32'h2);
        checkEq("prio_nofwd_stall", 32'(oBP_Stall), 1);
`endif
        step();
        idle();
        loadId(0, 4, 32'h99, 32'h4444);
        exWrite(0, 32'hFFFF, 0);
        settle();
        checkEq("r0_opa", oBP_ID_Operand_A, 0);
        checkEq("r0_stall", 32'(oBP_Stall), 0);
        checkEq("r0_opb", oBP_ID_Operand_B, 32'h4444);

        // Load-use stall interrupted by flush
        loadId(5, 6, 32'h5, 32'h6);
        exWrite(6, 32'h0, 1);
        settle();
        checkEq("fl_stall0", 32'(oBP_Stall), 1);
        step();
        idle();
        iFlush = 1;
        iIF_Valid = 1; iIF_RF_Read_Addr_A = 9;
        settle();
        checkEq("fl_stall_forced", 32'(oBP_Stall), 0);
        step();
        idle();
        settle();
        checkEq("fl_valid", 32'(oBP_ID_Valid), 0);
        checkEq("fl_stall_after", 32'(oBP_Stall), 0);
        step();
        settle();
        checkEq("fl_run", 32'(oBP_Stall), 0);

        // Index 30 lies beyond the architected file
        loadId(30, 27, 32'h3030, 32'h2727);
        wbWrite(30, 32'hABC);
        settle();
        checkEq("r30_opa", oBP_ID_Operand_A, 0);
        checkEq("r27_opb", oBP_ID_Operand_B, 32'h2727);
        step();
        idle();

        // Reset while in the wait state
        loadId(1, 2, 32'h11, 32'h22);
        exWrite(2, 32'h0, 1);
        step();
        idle();
        iRst = 1;
        step();
        iRst = 0;
        settle();
        checkEq("mrst_stall", 32'(oBP_Stall), 0);
        checkEq("mrst_valid", 32'(oBP_ID_Valid), 0);
        checkEq("mrst_opa", oBP_ID_Operand_A, 0);
        checkEq("mrst_opb", oBP_ID_Operand_B, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
